// File: rtl/ananke_cb_sr_responder_pkg.sv
// Shared types and constants for the cluster system-register responder.
// No logic here; the top module and the register bank import these definitions.
// The capture struct holds one request so the FSM never re-samples the core.
package ananke_sr_pkg;

  localparam int SR_DW = 64;

  localparam logic [6:0] SR_ADDR_CNT = 7'h7E;
  localparam logic [6:0] SR_ADDR_ID  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    DRAIN
  } sr_state_t;

  typedef struct packed {
    logic             dest;
    logic [6:0]       addr;
    logic             write;
    logic [SR_DW-1:0] wdata;
  } sr_req_t;

endpackage

// File: rtl/ananke_cb_sr_responder_if.sv
// Core-to-cluster system-register side channel: request bundle plus ack/data return.
// The master is the core (requester), the slave is the cluster responder.
// Req is a level held by the master until it has seen the one-cycle ack.
interface ananke_cb_sr_responder_if #(
  parameter int NUM_REGS = 8
);
  import ananke_sr_pkg::*;

  logic                      cpu_srreq_i;
  logic                      cpu_srdest_i;
  logic [6:0]                cpu_sraddr_i;
  logic                      cpu_srwrite_i;
  logic [SR_DW-1:0]          cpu_srwdata_i;
  logic [3:0]                cb_coreid_i;
  logic                      cb_srack_o;
  logic [SR_DW-1:0]          cb_srrdata_o;
  logic [NUM_REGS*SR_DW-1:0] cb_srregs_o;
  logic [NUM_REGS-1:0]       cb_srwrpulse_o;

  modport master (
    output cpu_srreq_i, cpu_srdest_i, cpu_sraddr_i, cpu_srwrite_i, cpu_srwdata_i, cb_coreid_i,
    input  cb_srack_o, cb_srrdata_o, cb_srregs_o, cb_srwrpulse_o
  );

  modport slave (
    input  cpu_srreq_i, cpu_srdest_i, cpu_sraddr_i, cpu_srwrite_i, cpu_srwdata_i, cb_coreid_i,
    output cb_srack_o, cb_srrdata_o, cb_srregs_o, cb_srwrpulse_o
  );

endinterface

// File: rtl/ananke_cb_sr_responder_regbank.sv
// Bank of NUM_REGS writable 64-bit registers with a combinational read mux.
// Write lands on the clock edge after i_we; o_wrpulse is high in the cycle the new value appears.
// No backpressure: every write strobe is accepted.
module ananke_sr_regbank
  import ananke_sr_pkg::*;
#(
  parameter int               NUM_REGS  = 8,
  parameter logic [SR_DW-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [6:0]                i_waddr,
  input  logic [SR_DW-1:0]          i_wdata,
  input  logic [6:0]                i_raddr,
  output logic [SR_DW-1:0]          o_rdata,
  output logic [NUM_REGS*SR_DW-1:0] o_regs,
  output logic [NUM_REGS-1:0]       o_wrpulse
);

  logic [NUM_REGS*SR_DW-1:0] r_bank;
  logic [NUM_REGS-1:0]       r_wrpulse;

  // Commit the write and raise the matching pulse on the same edge; equal-value writes still pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank    <= {NUM_REGS{RESET_VAL}};
      r_wrpulse <= '0;
    end else begin
      r_wrpulse <= '0;
      for (int n = 0; n < NUM_REGS; n++) begin
        if (i_we && (i_waddr == 7'(n))) begin
          r_bank[n*SR_DW +: SR_DW] <= i_wdata;
          r_wrpulse[n]             <= 1'b1;
        end
      end
    end
  end

  // Read mux; addresses outside the bank resolve to zero
  always_comb begin
    o_rdata = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (i_raddr == 7'(n)) o_rdata = r_bank[n*SR_DW +: SR_DW];
    end
  end

  assign o_regs    = r_bank;
  assign o_wrpulse = r_wrpulse;

endmodule

// File: rtl/ananke_cb_sr_responder.sv
// Cluster-side system-register responder: captures one core request, acks it, commits writes.
// Ack pulses ACK_LATENCY+1 cycles after req is first seen; read data valid only in the ack cycle.
// Requester holds req until ack; we wait for req to drop before accepting the next request.
module ananke_cb_sr_responder
  import ananke_sr_pkg::*;
#(
  parameter int               NUM_REGS    = 8,
  parameter int               ACK_LATENCY = 2,
  parameter logic [SR_DW-1:0] RESET_VAL   = '0
) (
  input logic                     clk,
  input logic                     warmreset,
  ananke_cb_sr_responder_if.slave sr
);

  sr_state_t        r_state;
  sr_req_t          r_req;
  logic [1:0]       r_lat;
  logic             r_ack;
  logic [SR_DW-1:0] r_rdata;
  logic [31:0]      r_sr_cnt;

  sr_req_t          w_cap;
  logic             w_in_bank;
  logic             w_bank_we;
  logic [SR_DW-1:0] w_bank_rdata;
  logic [SR_DW-1:0] w_rd_val;

  assign w_cap = '{dest:  sr.cpu_srdest_i,
                   addr:  sr.cpu_sraddr_i,
                   write: sr.cpu_srwrite_i,
                   wdata: sr.cpu_srwdata_i};

  assign w_in_bank = (r_req.addr < 7'(NUM_REGS));
  // Writes commit on the edge that ends the ack cycle; dest=1 space is write-ignored
  assign w_bank_we = (r_state == ACK) && r_req.write && !r_req.dest && w_in_bank;

  // Address decode of the captured request; writes and unimplemented space read as zero
  always_comb begin
    w_rd_val = '0;
    if (!r_req.dest && !r_req.write) begin
      if (w_in_bank)                       w_rd_val = w_bank_rdata;
      else if (r_req.addr == SR_ADDR_CNT)  w_rd_val = {32'h0, r_sr_cnt};
      else if (r_req.addr == SR_ADDR_ID)   w_rd_val = {60'h0, sr.cb_coreid_i};
    end
  end

  // Request FSM with registered ack/rdata; DRAIN blocks re-accept while the core still holds req
  always_ff @(posedge clk or posedge warmreset) begin
    if (warmreset) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_lat   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (sr.cpu_srreq_i) begin
            r_req   <= w_cap;
            r_lat   <= 2'(ACK_LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_lat == 2'd0) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_rdata <= w_rd_val;
          end else begin
            r_lat <= r_lat - 2'd1;
          end
        end
        ACK:     r_state <= DRAIN;
        DRAIN:   if (!sr.cpu_srreq_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating count of acked transactions, including unimplemented-space ones
  always_ff @(posedge clk or posedge warmreset) begin
    if (warmreset)                                        r_sr_cnt <= '0;
    else if ((r_state == ACK) && (r_sr_cnt != 32'hFFFF_FFFF)) r_sr_cnt <= r_sr_cnt + 32'd1;
  end

  ananke_sr_regbank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regbank (
    .clk       (clk),
    .rst       (warmreset),
    .i_we      (w_bank_we),
    .i_waddr   (r_req.addr),
    .i_wdata   (r_req.wdata),
    .i_raddr   (r_req.addr),
    .o_rdata   (w_bank_rdata),
    .o_regs    (sr.cb_srregs_o),
    .o_wrpulse (sr.cb_srwrpulse_o)
  );

  assign sr.cb_srack_o   = r_ack;
  assign sr.cb_srrdata_o = r_rdata;

endmodule
